// File: rtl/rom_entry_arbiter_pkg.sv
// Shared decode definitions for the microcode ROM entry arbiter and sequencer:
// state encoding, program indices, program lengths and grant vector layout.
package rom_entry_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } arb_state_e;

  localparam logic [2:0] PROG_NONE = 3'd0;
  localparam logic [2:0] PROG_INT  = 3'd6;
  localparam logic [2:0] PROG_EXC  = 3'd7;

  // Programs the decoder itself may request.
  localparam logic [2:0] DEC_PROG_MIN = 3'd1;
  localparam logic [2:0] DEC_PROG_MAX = 3'd5;

  localparam int unsigned IF_BIT_DEF = 9;

  typedef struct packed {
    logic exc;
    logic nmi;
    logic intr;
    logic dec;
  } grant_t;

  function automatic logic dec_prog_ok(input logic [2:0] prog);
    return (prog >= DEC_PROG_MIN) && (prog <= DEC_PROG_MAX);
  endfunction

  // Micro-op count of each program; the sequencer raises rom_ready on the last one.
  function automatic logic [3:0] rom_prog_len(input logic [2:0] prog);
    logic [3:0] len;
    case (prog)
      3'd1:    len = 4'd3;
      3'd2:    len = 4'd5;
      3'd3:    len = 4'd2;
      3'd4:    len = 4'd6;
      3'd5:    len = 4'd8;
      3'd6:    len = 4'd7;
      3'd7:    len = 4'd7;
      default: len = 4'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/rom_entry_arbiter_prio.sv
// Combinational fixed-priority selector for ROM program entry:
// exception > NMI > interrupt > decoder; returns one-hot grant, program and vector.
module rom_entry_prio
  import rom_entry_arbiter_pkg::*;
#(
  parameter logic [2:0] INT_PROG = PROG_INT,
  parameter logic [2:0] EXC_PROG = PROG_EXC,
  parameter logic [2:0] NMI_PROG = PROG_INT
) (
  input  logic       enable,
  input  logic       exc_req,
  input  logic [7:0] exc_code,
  input  logic       nmi_req,
  input  logic [7:0] nmi_vector,
  input  logic       int_req,
  input  logic [7:0] int_vector,
  input  logic       dec_req,
  input  logic [2:0] dec_prog,
  output grant_t     grant,
  output logic [2:0] prog,
  output logic [7:0] vector
);

  always_comb begin
    grant  = '0;
    prog   = PROG_NONE;
    vector = '0;
    if (enable) begin
      if (exc_req) begin
        grant.exc = 1'b1;
        prog      = EXC_PROG;
        vector    = exc_code;
      end else if (nmi_req) begin
        grant.nmi = 1'b1;
        prog      = NMI_PROG;
        vector    = nmi_vector;
      end else if (int_req) begin
        grant.intr = 1'b1;
        prog       = INT_PROG;
        vector     = int_vector;
      end else if (dec_req && dec_prog_ok(dec_prog)) begin
        grant.dec = 1'b1;
        prog      = dec_prog;
      end
    end
  end

endmodule

// File: rtl/rom_entry_arbiter.sv
// Microcode ROM entry arbiter: grants exception/interrupt/decoder programs and
// holds the ROM in control until the last micro-op is accepted. Optional NMI: ROM_ARB_NMI_EN.
module rom_entry_arbiter
  import rom_entry_arbiter_pkg::*;
#(
`ifdef ROM_ARB_NMI_EN
  parameter logic [2:0]  NMI_PROG = 3'd6,
`endif
  parameter logic [2:0]  INT_PROG = PROG_INT,
  parameter logic [2:0]  EXC_PROG = PROG_EXC,
  parameter int unsigned IF_BIT   = IF_BIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_req,
  input  logic [7:0]  exc_code,
  input  logic        int_req,
  input  logic [7:0]  int_vector,
  input  logic        dec_rom_req,
  input  logic [2:0]  dec_rom_prog,
  output logic        dec_rom_ack,
  output logic        int_ack,
  output logic        exc_ack,
`ifdef ROM_ARB_NMI_EN
  input  logic        nmi_req,
  input  logic [7:0]  nmi_vector,
  output logic        nmi_ack,
`endif
  input  logic [31:0] eflags_reg,
  input  logic        flush,
  input  logic        s0_valid,
  input  logic        s0_ready,
  input  logic        s1_valid,
  input  logic        s1_ready,
  input  logic        rom_ready,
  output logic [2:0]  rom_control,
  output logic        rom_in_control,
  output logic [7:0]  vector_q,
  output logic        busy
);

  arb_state_e state;
  logic       int_pend;
  logic [7:0] int_vec_q;
  logic       int_ok;
  logic [7:0] int_vec_sel;
  logic       int_live_taken;
  logic       nmi_ok;
  logic [7:0] nmi_vec_sel;
  logic       enable;
  grant_t     grant;
  logic [2:0] sel_prog;
  logic [7:0] sel_vector;
  logic       unused_flags;

  assign unused_flags = ^eflags_reg;

  assign enable      = (state == IDLE) && !flush && !reset;
  assign int_ok      = (int_pend | int_req) & eflags_reg[IF_BIT];
  // An older pending interrupt is served before a pulse arriving this cycle.
  assign int_vec_sel = int_pend ? int_vec_q : int_vector;

`ifdef ROM_ARB_NMI_EN
  logic       nmi_pend;
  logic [7:0] nmi_vec_q;
  logic       nmi_live_taken;

  assign nmi_ok         = nmi_pend | nmi_req;
  assign nmi_vec_sel    = nmi_pend ? nmi_vec_q : nmi_vector;
  assign nmi_ack        = grant.nmi;
  assign nmi_live_taken = nmi_ack & ~nmi_pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      nmi_pend  <= 1'b0;
      nmi_vec_q <= '0;
    end else begin
      nmi_pend <= nmi_ack ? (nmi_pend & nmi_req) : (nmi_pend | nmi_req);
      if (nmi_req && !nmi_live_taken)
        nmi_vec_q <= nmi_vector;
    end
  end
`else
  assign nmi_ok      = 1'b0;
  assign nmi_vec_sel = '0;
`endif

  rom_entry_prio #(
    .INT_PROG (INT_PROG),
    .EXC_PROG (EXC_PROG),
`ifdef ROM_ARB_NMI_EN
    .NMI_PROG (NMI_PROG)
`else
    .NMI_PROG (INT_PROG)
`endif
  ) u_prio (
    .enable     (enable),
    .exc_req    (exc_req),
    .exc_code   (exc_code),
    .nmi_req    (nmi_ok),
    .nmi_vector (nmi_vec_sel),
    .int_req    (int_ok),
    .int_vector (int_vec_sel),
    .dec_req    (dec_rom_req),
    .dec_prog   (dec_rom_prog),
    .grant      (grant),
    .prog       (sel_prog),
    .vector     (sel_vector)
  );

  assign exc_ack     = grant.exc;
  assign int_ack     = grant.intr;
  assign dec_rom_ack = grant.dec;

  // A grant that consumed the live pulse clears the latch; otherwise a new pulse re-arms it.
  assign int_live_taken = int_ack & ~int_pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      int_pend  <= 1'b0;
      int_vec_q <= '0;
    end else begin
      int_pend <= int_ack ? (int_pend & int_req) : (int_pend | int_req);
      if (int_req && !int_live_taken)
        int_vec_q <= int_vector;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      rom_control    <= PROG_NONE;
      rom_in_control <= 1'b0;
      vector_q       <= '0;
      busy           <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant != '0) begin
            state          <= START;
            rom_control    <= sel_prog;
            rom_in_control <= 1'b1;
            busy           <= 1'b1;
            if (!grant.dec)
              vector_q <= sel_vector;
          end
        end
        START: begin
          if (flush) begin
            state          <= IDLE;
            rom_control    <= PROG_NONE;
            rom_in_control <= 1'b0;
            busy           <= 1'b0;
          end else if (s0_valid && s0_ready) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (flush || (s1_valid && s1_ready && rom_ready)) begin
            state          <= IDLE;
            rom_control    <= PROG_NONE;
            rom_in_control <= 1'b0;
            busy           <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          rom_control    <= PROG_NONE;
          rom_in_control <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_entry_arbiter.sv
// Self-checking bench for rom_entry_arbiter: directed scenarios followed by
// randomized traffic, all checked against a behavioural program-tracking model.
module tb_rom_entry_arbiter;

  localparam int IF_BIT = 9;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_req;
  logic [7:0]  exc_code;
  logic        int_req;
  logic [7:0]  int_vector;
  logic        dec_rom_req;
  logic [2:0]  dec_rom_prog;
  logic        dec_rom_ack;
  logic        int_ack;
  logic        exc_ack;
  logic [31:0] eflags_reg;
  logic        flush;
  logic        s0_valid, s0_ready, s1_valid, s1_ready;
  logic        rom_ready;
  logic [2:0]  rom_control;
  logic        rom_in_control;
  logic [7:0]  vector_q;
  logic        busy;
`ifdef ROM_ARB_NMI_EN
  logic        nmi_req;
  logic [7:0]  nmi_vector;
  logic        nmi_ack;
`endif

  always #5 clk = ~clk;

  rom_entry_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .exc_req        (exc_req),
    .exc_code       (exc_code),
    .int_req        (int_req),
    .int_vector     (int_vector),
    .dec_rom_req    (dec_rom_req),
    .dec_rom_prog   (dec_rom_prog),
    .dec_rom_ack    (dec_rom_ack),
    .int_ack        (int_ack),
    .exc_ack        (exc_ack),
`ifdef ROM_ARB_NMI_EN
    .nmi_req        (nmi_req),
    .nmi_vector     (nmi_vector),
    .nmi_ack        (nmi_ack),
`endif
    .eflags_reg     (eflags_reg),
    .flush          (flush),
    .s0_valid       (s0_valid),
    .s0_ready       (s0_ready),
    .s1_valid       (s1_valid),
    .s1_ready       (s1_ready),
    .rom_ready      (rom_ready),
    .rom_control    (rom_control),
    .rom_in_control (rom_in_control),
    .vector_q       (vector_q),
    .busy           (busy)
  );

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: which program (0 = none) the ROM is running, whether the
  // stage-0 restart happened, and the outstanding interrupt event.
  int m_prog    = 0;
  bit m_started = 0;
  int m_vec     = 0;
  bit m_pend    = 0;
  int m_pvec    = 0;
  bit e_exc, e_int, e_dec;

  task automatic predict_acks();
    bit free;
    bit int_wanted;
    free       = (m_prog == 0) && !flush && !reset;
    int_wanted = (m_pend || int_req) && eflags_reg[IF_BIT];
    e_exc = free && exc_req;
    e_int = free && !exc_req && int_wanted;
    e_dec = free && !exc_req && !int_wanted && dec_rom_req &&
            (int'(dec_rom_prog) >= 1) && (int'(dec_rom_prog) <= 5);
  endtask

  task automatic model_update();
    bit consumed_live;
    if (reset) begin
      m_prog = 0; m_started = 0; m_vec = 0; m_pend = 0; m_pvec = 0;
    end else begin
      if (e_exc) begin
        m_prog = 7; m_vec = int'(exc_code);
      end else if (e_int) begin
        m_prog = 6; m_vec = m_pend ? m_pvec : int'(int_vector);
      end else if (e_dec) begin
        m_prog = int'(dec_rom_prog);
      end else if (m_prog != 0) begin
        if (flush) begin
          m_prog = 0; m_started = 0;
        end else if (!m_started) begin
          m_started = s0_valid && s0_ready;
        end else if (s1_valid && s1_ready && rom_ready) begin
          m_prog = 0; m_started = 0;
        end
      end
      consumed_live = e_int && !m_pend;
      if (e_int) m_pend = 0;
      if (int_req && !consumed_live) begin
        m_pend = 1; m_pvec = int'(int_vector);
      end
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    #1;
    predict_acks();
    check("exc_ack", 32'(exc_ack), 32'(e_exc));
    check("int_ack", 32'(int_ack), 32'(e_int));
    check("dec_ack", 32'(dec_rom_ack), 32'(e_dec));
    @(posedge clk);
    model_update();
    @(negedge clk);
    check("rom_control", 32'(rom_control), 32'(m_prog));
    check("rom_in_control", 32'(rom_in_control), 32'(m_prog != 0));
    check("busy", 32'(busy), 32'(m_prog != 0));
    check("vector_q", 32'(vector_q), 32'(m_vec));
  endtask

  task automatic quiet_inputs();
    reset = 0; exc_req = 0; exc_code = '0; int_req = 0; int_vector = '0;
    dec_rom_req = 0; dec_rom_prog = '0; flush = 0;
    s0_valid = 0; s0_ready = 0; s1_valid = 0; s1_ready = 0; rom_ready = 0;
`ifdef ROM_ARB_NMI_EN
    nmi_req = 0; nmi_vector = '0;
`endif
  endtask

  // Drive one stage-0 accept then one final stage-1 accept.
  task automatic finish_prog();
    s0_valid = 1; s0_ready = 1;
    step();
    s0_valid = 0; s0_ready = 0;
    s1_valid = 1; s1_ready = 1; rom_ready = 1;
    step();
    s1_valid = 0; s1_ready = 0; rom_ready = 0;
  endtask

  initial begin
    quiet_inputs();
    eflags_reg = 32'h0000_0200;
    reset = 1;
    @(negedge clk);
    step();
    step();
    check("reset_rom_control", 32'(rom_control), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    reset = 0;

    // Decoder program 3 with two stage-1 accepts, last one with rom_ready.
    dec_rom_req = 1; dec_rom_prog = 3'd3;
    step();
    dec_rom_req = 0;
    check("dec_prog3", 32'(rom_control), 32'd3);
    check("dec_in_ctl", 32'(rom_in_control), 32'd1);
    s0_valid = 1; s0_ready = 1; step(); s0_valid = 0; s0_ready = 0;
    s1_valid = 1; s1_ready = 1; step();
    check("dec_mid_run", 32'(rom_control), 32'd3);
    rom_ready = 1; step();
    s1_valid = 0; s1_ready = 0; rom_ready = 0;
    check("dec_done", 32'(rom_control), 32'd0);

    // Interrupt with IF=1.
    int_req = 1; int_vector = 8'h20;
    step();
    int_req = 0;
    check("int_prog", 32'(rom_control), 32'd6);
    check("int_vec", 32'(vector_q), 32'h20);
    finish_prog();

    // Interrupt with IF=0 stays pending, then IF raised.
    eflags_reg = 32'h0;
    int_req = 1; int_vector = 8'h21;
    step();
    int_req = 0;
    repeat (3) step();
    check("int_masked", 32'(rom_control), 32'd0);
    eflags_reg = 32'h0000_0200;
    step();
    check("int_unmasked", 32'(rom_control), 32'd6);
    check("int_unmasked_vec", 32'(vector_q), 32'h21);
    finish_prog();

    // Exception and interrupt together: exception first, interrupt afterwards.
    exc_req = 1; exc_code = 8'h0E; int_req = 1; int_vector = 8'h30;
    step();
    exc_req = 0; int_req = 0;
    check("exc_prog", 32'(rom_control), 32'd7);
    check("exc_vec", 32'(vector_q), 32'h0E);
    finish_prog();
    step();
    check("int_after_exc", 32'(rom_control), 32'd6);
    check("int_after_exc_vec", 32'(vector_q), 32'h30);
    finish_prog();

    // Flush during RUN of program 2.
    dec_rom_req = 1; dec_rom_prog = 3'd2;
    step();
    dec_rom_req = 0;
    s0_valid = 1; s0_ready = 1; step(); s0_valid = 0; s0_ready = 0;
    s1_valid = 1; s1_ready = 1; step(); s1_valid = 0; s1_ready = 0;
    flush = 1; step(); flush = 0;
    check("flush_clears", 32'(rom_control), 32'd0);

    // Illegal decoder program is never acknowledged.
    dec_rom_req = 1; dec_rom_prog = 3'd7;
    repeat (4) step();
    dec_rom_req = 0;
    check("illegal_prog", 32'(rom_control), 32'd0);

    // Reset in the middle of a program.
    dec_rom_req = 1; dec_rom_prog = 3'd4;
    step();
    dec_rom_req = 0;
    s0_valid = 1; s0_ready = 1; step(); s0_valid = 0; s0_ready = 0;
    reset = 1; step(); reset = 0;
    check("reset_mid_ctl", 32'(rom_control), 32'd0);
    check("reset_mid_vec", 32'(vector_q), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      exc_req    = ($urandom_range(0, 19) == 0);
      exc_code   = 8'($urandom);
      int_req    = ($urandom_range(0, 9) == 0);
      int_vector = 8'($urandom);
      eflags_reg = $urandom;
      eflags_reg[IF_BIT] = ($urandom_range(0, 3) != 0);
      if (!dec_rom_req || $urandom_range(0, 15) == 0) begin
        dec_rom_req  = ($urandom_range(0, 2) == 0);
        dec_rom_prog = 3'($urandom_range(0, 7));
      end
      flush     = ($urandom_range(0, 15) == 0);
      s0_valid  = $urandom_range(0, 1) == 1;
      s0_ready  = $urandom_range(0, 1) == 1;
      s1_valid  = $urandom_range(0, 1) == 1;
      s1_ready  = $urandom_range(0, 1) == 1;
      rom_ready = $urandom_range(0, 2) == 0;
      step();
      if (e_dec) dec_rom_req = 0;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
